// File: rtl/tl_pkg.sv
// Shared encodings for the traffic-light colour classifier.
// Colour codes, FSM states, RGB332 thresholds and the default line width.
package tl_pkg;

    typedef enum logic [1:0] {
        CLR_NONE   = 2'd0,
        CLR_RED    = 2'd1,
        CLR_YELLOW = 2'd2,
        CLR_GREEN  = 2'd3
    } color_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SCAN   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DECIDE = 3'd4,
        ST_HOLD   = 3'd5
    } state_e;

    localparam logic [2:0] TH_HI  = 3'd5;
    localparam logic [2:0] TH_LO  = 3'd2;
    localparam logic [1:0] TH_BLO = 2'd1;

    localparam int IMG_W_DEF = 200;

endpackage

// File: rtl/rgb332_classify.sv
// Combinational RGB332 pixel classifier.
// Maps one pixel to RED, YELLOW, GREEN or NONE.
module rgb332_classify
    import tl_pkg::*;
(
    input  logic [7:0] pixel,
    output color_e     cls
);

    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    logic       is_yel;
    logic       is_red;
    logic       is_grn;

    assign r = pixel[7:5];
    assign g = pixel[4:2];
    assign b = pixel[1:0];

    // The three classes cannot overlap: red needs low G, green needs low R.
    assign is_yel = (r >= TH_HI) && (g >= TH_HI) && (b <= TH_BLO);
    assign is_red = (r >= TH_HI) && (g <= TH_LO) && (b <= TH_BLO);
    assign is_grn = (g >= TH_HI) && (r <= TH_LO);

    always_comb begin
        cls = CLR_NONE;
        unique case (1'b1)
            is_yel:  cls = CLR_YELLOW;
            is_red:  cls = CLR_RED;
            is_grn:  cls = CLR_GREEN;
            default: cls = CLR_NONE;
        endcase
    end

endmodule

// File: rtl/tl_color_classify.sv
// Scans the detector's framed region in ROM and reports the dominant light colour.
// Optional TL_BORDER_SKIP_EN excludes a BORDER-pixel margin from the counts.
module tl_color_classify
    import tl_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int ROM_LAT = 1,
    parameter int MIN_PIX = 16,
    parameter int CNT_W   = 12,
    parameter int BORDER  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flag_addr,
    input  logic [15:0] square_begin,
    input  logic [15:0] square_end,
    input  logic [7:0]  pixel,
    output logic [15:0] rom_addr,
    output logic        rom_rd,
    output logic [1:0]  light_color,
    output logic        light_valid,
    output logic        box_err
);

    localparam logic [15:0]      STRIDE  = 16'(IMG_W);
    localparam logic [15:0]      BRD     = 16'(BORDER);
    localparam logic [15:0]      BRD2    = 16'(2 * BORDER);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIX);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_e state_q;
    state_e state_d;

    logic        flag_q;
    logic [15:0] base_q;
    logic [15:0] diff_q;
    logic [15:0] h_q;
    logic [15:0] w_q;
    logic [15:0] row_base_q;
    logic [15:0] col_q;
    logic [15:0] row_q;
    logic [15:0] addr_q;

    logic [ROM_LAT-1:0] vld_q;
    logic [ROM_LAT-1:0] cnt_q;

    logic [CNT_W-1:0] red_q;
    logic [CNT_W-1:0] yel_q;
    logic [CNT_W-1:0] grn_q;
    logic [CNT_W-1:0] win_cnt;

    color_e pix_cls;
    color_e win_cls;
    color_e dec_cls;

    logic rise;
    logic box_ok;
    logic abort;
    logic setup_done;
    logic geom_bad;
    logic scan_start;
    logic scan;
    logic last_col;
    logic last_pix;
    logic skip_on;
    logic inner_geo;
    logic inner;
    logic drain_busy;
    logic count_en;
    logic err_d;
    logic valid_d;

    assign rise       = flag_addr & ~flag_q;
    assign box_ok     = square_end > square_begin;
    assign abort      = ~flag_addr && (state_q == ST_SETUP ||
                        state_q == ST_SCAN || state_q == ST_DRAIN);
    assign setup_done = diff_q < STRIDE;
    assign geom_bad   = (h_q > 16'd255) || (diff_q == 16'd0);
    assign scan_start = (state_q == ST_SETUP) && !abort &&
                        setup_done && !geom_bad;
    assign scan       = state_q == ST_SCAN;
    assign last_col   = col_q == w_q;
    assign last_pix   = last_col && (row_q == h_q);

    assign rom_rd   = scan;
    assign rom_addr = scan ? row_base_q + col_q : addr_q;

`ifdef TL_BORDER_SKIP_EN
    assign skip_on = 1'b1;
`else
    assign skip_on = 1'b0;
`endif

    assign inner_geo = (w_q >= BRD2) && (h_q >= BRD2) &&
                       (col_q >= BRD) && (col_q + BRD <= w_q) &&
                       (row_q >= BRD) && (row_q + BRD <= h_q);
    assign inner = ~skip_on | inner_geo;

    // Only the stages before the last one matter: the last is consumed now.
    always_comb begin
        drain_busy = 1'b0;
        for (int i = 0; i < ROM_LAT - 1; i++) begin
            drain_busy = drain_busy | vld_q[i];
        end
    end

    assign count_en = vld_q[ROM_LAT-1] & cnt_q[ROM_LAT-1] & ~abort;

    rgb332_classify u_cls (
        .pixel (pixel),
        .cls   (pix_cls)
    );

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        valid_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    if (box_ok) state_d = ST_SETUP;
                    else        err_d   = 1'b1;
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (setup_done) begin
                    if (geom_bad) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                if (abort)         state_d = ST_IDLE;
                else if (last_pix) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort)           state_d = ST_IDLE;
                else if (!drain_busy) state_d = ST_DECIDE;
            end
            ST_DECIDE: begin
                valid_d = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!flag_addr) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ties resolve RED over YELLOW over GREEN.
    always_comb begin
        win_cls = CLR_GREEN;
        win_cnt = grn_q;
        if (red_q >= yel_q && red_q >= grn_q) begin
            win_cls = CLR_RED;
            win_cnt = red_q;
        end else if (yel_q >= grn_q) begin
            win_cls = CLR_YELLOW;
            win_cnt = yel_q;
        end
        dec_cls = (win_cnt < MIN_CNT) ? CLR_NONE : win_cls;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            flag_q      <= 1'b0;
            box_err     <= 1'b0;
            light_valid <= 1'b0;
            light_color <= 2'd0;
        end else begin
            state_q     <= state_d;
            flag_q      <= flag_addr;
            box_err     <= err_d;
            light_valid <= valid_d;
            if (state_q == ST_DECIDE) light_color <= dec_cls;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= 16'd0;
            diff_q     <= 16'd0;
            h_q        <= 16'd0;
            w_q        <= 16'd0;
            row_base_q <= 16'd0;
            col_q      <= 16'd0;
            row_q      <= 16'd0;
            addr_q     <= 16'd0;
        end else begin
            if (state_q == ST_IDLE && rise && box_ok) begin
                base_q <= square_begin;
                diff_q <= square_end - square_begin;
                h_q    <= 16'd0;
            end
            if (state_q == ST_SETUP && !setup_done) begin
                diff_q <= diff_q - STRIDE;
                h_q    <= h_q + 16'd1;
            end
            if (scan_start) begin
                w_q        <= diff_q;
                row_base_q <= base_q;
                col_q      <= 16'd0;
                row_q      <= 16'd0;
            end
            if (scan) begin
                addr_q <= row_base_q + col_q;
                if (last_col) begin
                    col_q      <= 16'd0;
                    row_base_q <= row_base_q + STRIDE;
                    row_q      <= row_q + 16'd1;
                end else begin
                    col_q <= col_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cnt_q <= '0;
        end else if (abort) begin
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q[0] <= rom_rd;
            cnt_q[0] <= rom_rd & inner;
            for (int i = 1; i < ROM_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                cnt_q[i] <= cnt_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_q <= '0;
            yel_q <= '0;
            grn_q <= '0;
        end else if (scan_start) begin
            red_q <= '0;
            yel_q <= '0;
            grn_q <= '0;
        end else if (count_en) begin
            unique case (pix_cls)
                CLR_RED:    if (red_q != '1) red_q <= red_q + ONE;
                CLR_YELLOW: if (yel_q != '1) yel_q <= yel_q + ONE;
                CLR_GREEN:  if (grn_q != '1) grn_q <= grn_q + ONE;
                default:    ;
            endcase
        end
    end

endmodule

// File: doc/tl_color_classify.md
Name: tl_color_classify

Overview:
- Downstream consumer of the black-frame detector. Starts when the detector's frame-valid flag asserts, then uses the detector's begin/end pixel addresses.
- Scans the framed region of the 200-px-wide RGB332 image ROM and counts red, yellow and green pixels.
- Reports the traffic-light colour with the largest count, once per detection.
- Owns the ROM read address while scanning.

Parameters:
- IMG_W, 200: image line width in pixels (address stride).
- ROM_LAT, 1: ROM read latency in clk cycles (1..3).
- MIN_PIX, 16: minimum winning count; below it the result is NONE.
- CNT_W, 12: width of the colour counters, which saturate.
- BORDER, 2: margin in pixels excluded when BORDER_SKIP_EN is defined.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- flag_addr  in  1  frame-valid level from the detector.
- square_begin  in  16  top-left pixel address of the frame.
- square_end  in  16  bottom-right pixel address of the frame.
- pixel  in  8  ROM data {R[2:0],G[2:0],B[1:0]}, valid ROM_LAT cycles after rom_addr.
- rom_addr  out  16  ROM read address.
- rom_rd  out  1  read strobe; high when rom_addr is a scan address.
- light_color  out  2  0 NONE, 1 RED, 2 YELLOW, 3 GREEN.
- light_valid  out  1  one-cycle pulse when light_color updates.
- box_err  out  1  one-cycle pulse when the geometry is rejected.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
- IDLE:
  - Start on the rising edge of flag_addr (registered previous value) with square_end > square_begin.
  - Latch begin/end, set diff = end - begin, go to SETUP.
  - A rising edge with end <= begin pulses box_err and stays in IDLE.
- SETUP (iterative division, one subtraction per cycle):
  - While diff >= IMG_W: diff -= IMG_W, h++.
  - Result: w = diff (last column offset), h = last row offset.
  - If h > 255 or w == 0: box_err pulse, go to IDLE.
  - Otherwise clear the counters, set row_base = begin, col = 0, row = 0, go to SCAN.
- SCAN:
  - Each cycle: rom_addr = row_base + col, rom_rd = 1.
  - col wraps at w; on wrap row_base += IMG_W and row++.
  - Last address: row == h and col == w. After it, go to DRAIN.
- Read pipeline:
  - rom_rd delayed through a ROM_LAT-deep valid shift register; the delayed pixel is classified when the delayed valid is high.
- Classification (3-bit R, 3-bit G, 2-bit B):
  - YELLOW: R>=5, G>=5, B<=1.
  - RED: R>=5, G<=2, B<=1.
  - GREEN: G>=5, R<=2.
  - Otherwise no count. Classes are mutually exclusive; YELLOW is checked first.
- Counters saturate at 2^CNT_W-1.
- DRAIN: wait until the pipeline valid is empty (ROM_LAT cycles), then go to DECIDE.
- DECIDE (one cycle):
  - The maximum of the three counts wins; ties go RED > YELLOW > GREEN.
  - If max < MIN_PIX the result is NONE.
  - Register light_color, pulse light_valid, go to HOLD.
- HOLD: wait until flag_addr == 0, then go to IDLE. light_color keeps its value until the next DECIDE.
- flag_addr falling during SETUP, SCAN or DRAIN:
  - Abort to IDLE; rom_rd goes 0 the next cycle.
  - No light_valid; light_color unchanged; in-flight pixels discarded.
- Begin/end changing while busy: ignored, because the values were latched in IDLE.
- rom_addr: holds its last value outside SCAN.
- Latency: start edge to light_valid = 1 (IDLE) + (h+1) (SETUP) + (w+1)(h+1) (SCAN) + ROM_LAT (DRAIN) + 1 (DECIDE) cycles.

Optional Feature:
- Macro TL_BORDER_SKIP_EN.
- When defined: pixels with col < BORDER, col > w-BORDER, row < BORDER or row > h-BORDER are read but not counted. This excludes the black frame. If w or h < 2*BORDER, nothing is counted and the result is NONE.
- When undefined: every scanned pixel is counted.

Decomposition:
- Package tl_pkg holds:
  - colour encodings (NONE/RED/YELLOW/GREEN);
  - the state encoding (IDLE/SETUP/SCAN/DRAIN/DECIDE/HOLD);
  - RGB332 thresholds (HI=5, LO=2, BLO=1);
  - the IMG_W default.
- Sub-module: combinational rgb332_classify (pixel in, 2-bit class out), instanced once.

Test Plan:
- begin=1000, end=1000+4*200+9 (w=9, h=4), all pixels 0xE0 (red) -> 50 reads at 1000..1009, 1200.., …, 1800..1809; light_color=1, one light_valid pulse.
- Same box, 30 pixels 0xFC (yellow), 20 pixels 0x1C (green) -> light_color=2.
- Same box, 10 pixels 0xE0, remaining 40 pixels 0x00 -> 10 < MIN_PIX, so light_color=0 with light_valid pulse.
- end=500, begin=600 on a flag_addr rise -> box_err pulse, no rom_rd, stays IDLE.
- flag_addr dropped mid-SCAN (after 20 reads) -> rom_rd=0 next cycle, no light_valid, previous light_color retained; a fresh rise restarts from begin.
- With TL_BORDER_SKIP_EN, 10x10 box (w=h=9), border ring red, inner 6x6 green -> light_color=3. Without the macro -> red 64 vs green 36, so light_color=1.
